seven_segment_reader: RTL and testbench

- Reads back a multiplexed, active-low seven-segment display bus (segment lines plus per-digit select) and recovers the 4-bit hex value shown on each digit.
- It is the inverse of the team's hex-to-segment decoder. It sits on the board-test/loopback path so that software can check the displayed values.
- Patterns are filtered for stability, assembled into a full frame of NUM_DIGITS digits, and presented downstream on a valid/ready handshake.

---
 rtl/seven_segment_reader.sv | 161 ++++++++++++++++
 tb/tb_seven_segment_reader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_reader.sv
`default_nettype none
// ============================================================================
// Module  : seven_segment_reader
// Purpose : Recovers hex digits from a multiplexed active-low 7-segment bus.
// Revision: 1.0
// ============================================================================
module seven_segment_reader #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              segments_in,
  input  logic [NUM_DIGITS-1:0]   digit_sel_n,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    frame_drop
);

  localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_PRE = c_CNT_W'(STABLE_CYCLES - 2);

  localparam logic [0:0] c_COLLECT = 1'b0;
  localparam logic [0:0] c_PRESENT = 1'b1;

  logic [6:0]              r_seg_s1, r_seg_s2;
  logic [NUM_DIGITS-1:0]   r_sel_s1, r_sel_s2;
  logic [c_CNT_W-1:0]      r_cnt;
  logic                    r_evt;
  logic [0:0]              r_state;
  logic [NUM_DIGITS-1:0]   r_captured;
  logic [4*NUM_DIGITS-1:0] r_stage_hex;
  logic [NUM_DIGITS-1:0]   r_stage_err;
  logic                    r_frame_valid;
  logic [4*NUM_DIGITS-1:0] r_hex_out;
  logic [NUM_DIGITS-1:0]   r_err_mask;
  logic                    r_frame_drop;

  logic                    w_same;
  logic                    w_sel_ok;
  logic                    w_cap;
  logic [c_IDX_W-1:0]      w_idx;
  logic [3:0]              w_hex;
  logic                    w_err;

  assign frame_valid = r_frame_valid;
  assign hex_out     = r_hex_out;
  assign err_mask    = r_err_mask;
  assign frame_drop  = r_frame_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_sel_s1 <= '1;
      r_sel_s2 <= '1;
    end else begin
      r_seg_s1 <= segments_in;
      r_seg_s2 <= r_seg_s1;
      r_sel_s1 <= digit_sel_n;
      r_sel_s2 <= r_sel_s1;
    end
  end

  // Stage 1 is next cycle's stage 2, so comparing them keeps r_cnt aligned with
  // the stage-2 value it describes; r_evt fires the cycle r_cnt first hits max.
  assign w_same = ({r_seg_s1, r_sel_s1} == {r_seg_s2, r_sel_s2});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_evt <= 1'b0;
    end else begin
      if (!w_same)
        r_cnt <= '0;
      else if (r_cnt != c_CNT_MAX)
        r_cnt <= r_cnt + 1'b1;
      r_evt <= w_same && (r_cnt == c_CNT_PRE);
    end
  end

  assign w_sel_ok = $onehot(~r_sel_s2);
  assign w_cap    = r_evt && w_sel_ok;

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!r_sel_s2[i]) w_idx = c_IDX_W'(i);
  end

  always_comb begin
    w_hex = 4'h0;
    w_err = 1'b0;
    case (r_seg_s2)
      7'b1000000: w_hex = 4'h0;
      7'b1111001: w_hex = 4'h1;
      7'b0100100: w_hex = 4'h2;
      7'b0110000: w_hex = 4'h3;
      7'b0011001: w_hex = 4'h4;
      7'b0010010: w_hex = 4'h5;
      7'b0000010: w_hex = 4'h6;
      7'b1111000: w_hex = 4'h7;
      7'b0000000: w_hex = 4'h8;
      7'b0010000: w_hex = 4'h9;
      7'b0001000: w_hex = 4'hA;
      7'b0000011: w_hex = 4'hB;
      7'b1000110: w_hex = 4'hC;
      7'b0100001: w_hex = 4'hD;
      7'b0000110: w_hex = 4'hE;
      7'b0001110: w_hex = 4'hF;
      default:    w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= c_COLLECT;
      r_captured    <= '0;
      r_stage_hex   <= '0;
      r_stage_err   <= '0;
      r_frame_valid <= 1'b0;
      r_hex_out     <= '0;
      r_err_mask    <= '0;
      r_frame_drop  <= 1'b0;
    end else begin
      case (r_state)
        c_COLLECT: begin
          if (&r_captured) begin
            r_state       <= c_PRESENT;
            r_hex_out     <= r_stage_hex;
            r_err_mask    <= r_stage_err;
            r_frame_valid <= 1'b1;
          end else if (w_cap && !r_captured[w_idx]) begin
            r_stage_hex[w_idx*4 +: 4] <= w_hex;
            r_stage_err[w_idx]        <= w_err;
            r_captured[w_idx]         <= 1'b1;
          end
        end
        c_PRESENT: begin
          if (r_frame_valid && frame_ready) begin
            r_state       <= c_COLLECT;
            r_frame_valid <= 1'b0;
            r_captured    <= '0;
            r_stage_hex   <= '0;
            r_stage_err   <= '0;
          end else if (w_cap && ((w_hex != r_hex_out[w_idx*4 +: 4]) ||
                                 (w_err != r_err_mask[w_idx]))) begin
            r_frame_drop <= 1'b1;
          end
        end
        default: r_state <= c_COLLECT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_seven_segment_reader
// Purpose : Directed, table-driven bench for seven_segment_reader.
// Revision: 1.0
// ============================================================================
module tb_seven_segment_reader;

  localparam int c_ND = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [6:0]      segments_in;
  logic [c_ND-1:0] digit_sel_n;
  logic            frame_ready;
  logic            frame_valid;
  logic [15:0]     hex_out;
  logic [3:0]      err_mask;
  logic            frame_drop;

  seven_segment_reader #(.NUM_DIGITS(c_ND), .STABLE_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .segments_in(segments_in),
    .digit_sel_n(digit_sel_n), .frame_ready(frame_ready),
    .frame_valid(frame_valid), .hex_out(hex_out), .err_mask(err_mask),
    .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [27:0] glyphs;   // {d3, d2, d1, d0}
    logic [15:0] hex;
    logic [3:0]  err;
  } vec_t;

  vec_t vecs [5];

  int checks = 0;
  int errors = 0;
  int frame_count = 0;
  int valid_cycles = 0;
  logic prev_valid = 1'b0;
  logic [15:0] last_hex = '0;
  logic [3:0]  last_err = '0;

  // Frame monitor: counts rising edges of frame_valid and latches each frame.
  initial forever begin
    @(posedge clk);
    #1;
    if (frame_valid) begin
      valid_cycles++;
      if (!prev_valid) begin
        frame_count++;
        last_hex = hex_out;
        last_err = err_mask;
      end
    end
    prev_valid = frame_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic show(input int d, input logic [6:0] g, input int n);
    digit_sel_n = ~(4'b0001 << d);
    segments_in = g;
    repeat (n) @(negedge clk);
  endtask

  task automatic idle(input int n);
    digit_sel_n = '1;
    segments_in = '1;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_frame(input logic [27:0] glyphs);
    idle(3);
    for (int i = 0; i < c_ND; i++) show(i, glyphs[7*i +: 7], 20);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int fc;
    int vc;

    vecs[0] = '{glyphs: {7'h0E, 7'h78, 7'h19, 7'h40}, hex: 16'hF740, err: 4'b0000};
    vecs[1] = '{glyphs: {7'h12, 7'h30, 7'h24, 7'h79}, hex: 16'h5321, err: 4'b0000};
    vecs[2] = '{glyphs: {7'h08, 7'h10, 7'h00, 7'h02}, hex: 16'hA986, err: 4'b0000};
    vecs[3] = '{glyphs: {7'h06, 7'h21, 7'h46, 7'h03}, hex: 16'hEDCB, err: 4'b0000};
    vecs[4] = '{glyphs: {7'h3F, 7'h24, 7'h7F, 7'h40}, hex: 16'h0200, err: 4'b1010};

    rst_n       = 1'b0;
    frame_ready = 1'b1;
    digit_sel_n = '1;
    segments_in = '1;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(frame_valid), 32'd0);
    check("reset_hex",   32'(hex_out),     32'd0);
    check("reset_err",   32'(err_mask),    32'd0);
    check("reset_drop",  32'(frame_drop),  32'd0);
    rst_n = 1'b1;
    idle(5);

    // Full glyph set plus illegal patterns, ready held high.
    for (int v = 0; v < 5; v++) begin
      fc = frame_count;
      vc = valid_cycles;
      scan_frame(vecs[v].glyphs);
      check($sformatf("vec%0d_frames", v), 32'(frame_count), 32'(fc + 1));
      check($sformatf("vec%0d_pulse", v),  32'(valid_cycles - vc), 32'd1);
      check($sformatf("vec%0d_hex", v),    32'(last_hex), 32'(vecs[v].hex));
      check($sformatf("vec%0d_err", v),    32'(last_err), 32'(vecs[v].err));
    end

    // Short glitch on digit 2 must not be captured.
    fc = frame_count;
    idle(3);
    show(0, 7'h40, 20);
    show(1, 7'h79, 20);
    show(2, 7'h00, 5);
    show(2, 7'h24, 20);
    show(3, 7'h30, 20);
    check("glitch_frames", 32'(frame_count), 32'(fc + 1));
    check("glitch_hex",    32'(last_hex),    32'h3210);

    // Two digits selected at once never captures.
    fc = frame_count;
    idle(3);
    digit_sel_n = 4'b1100;
    segments_in = 7'h40;
    repeat (50) @(negedge clk);
    check("multisel_valid",  32'(frame_valid), 32'd0);
    check("multisel_frames", 32'(frame_count), 32'(fc));
    scan_frame(vecs[0].glyphs);
    check("after_multi_frames", 32'(frame_count), 32'(fc + 1));
    check("after_multi_hex",    32'(last_hex),    32'hF740);

    // Held frame with a changing digit sets the sticky drop flag.
    frame_ready = 1'b0;
    fc = frame_count;
    scan_frame({7'h30, 7'h24, 7'h79, 7'h12});
    check("hold_frames", 32'(frame_count), 32'(fc + 1));
    check("hold_valid",  32'(frame_valid), 32'd1);
    check("hold_hex",    32'(hex_out),     32'h3215);
    check("hold_drop0",  32'(frame_drop),  32'd0);
    show(0, 7'h12, 20);
    check("same_digit_drop", 32'(frame_drop), 32'd0);
    show(0, 7'h02, 20);
    check("changed_drop",  32'(frame_drop),  32'd1);
    check("changed_hex",   32'(hex_out),     32'h3215);
    check("changed_valid", 32'(frame_valid), 32'd1);
    frame_ready = 1'b1;
    @(negedge clk);
    check("handshake_valid", 32'(frame_valid), 32'd0);
    check("handshake_drop",  32'(frame_drop),  32'd1);
    fc = frame_count;
    scan_frame({7'h30, 7'h24, 7'h79, 7'h02});
    check("post_drop_frames", 32'(frame_count), 32'(fc + 1));
    check("post_drop_hex",    32'(last_hex),    32'h3216);
    check("post_drop_sticky", 32'(frame_drop),  32'd1);

    // Reset mid-frame after two digits are captured.
    idle(3);
    show(0, 7'h40, 20);
    show(1, 7'h79, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_hex",   32'(hex_out),     32'd0);
    check("midrst_drop",  32'(frame_drop),  32'd0);
    check("midrst_valid", 32'(frame_valid), 32'd0);
    check("midrst_err",   32'(err_mask),    32'd0);
    idle(3);
    rst_n = 1'b1;
    fc = frame_count;
    show(2, 7'h24, 20);
    show(3, 7'h30, 20);
    idle(10);
    check("partial_no_frame", 32'(frame_count), 32'(fc));
    show(0, 7'h40, 20);
    show(1, 7'h79, 20);
    check("rescan_frames", 32'(frame_count), 32'(fc + 1));
    check("rescan_hex",    32'(last_hex),    32'h3210);
    check("rescan_err",    32'(last_err),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
